// File: rtl/exp_fifo_port.sv
// Expansion-port peripheral: Z80 I/O data/status registers bridging an RX (host->CPC)
// and a TX (CPC->host) FIFO, with a level interrupt on RX data available.
module exp_fifo_port #(
  parameter logic [15:0] DATA_PORT  = 16'hFBD0,
  parameter logic [15:0] STAT_PORT  = 16'hFBD1,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  output logic [7:0]  cpu_din,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic io_cyc;
  logic rd_data_sel, rd_stat_sel, wr_data_sel, wr_stat_sel;
  logic rd_data_prev, rd_stat_prev, wr_data_prev, wr_stat_prev;
  logic rd_data_edge, rd_stat_edge, wr_data_edge, wr_stat_edge;

  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_count;

  logic rx_full, rx_avail, tx_full, tx_avail;
  logic rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_drop, flush;
  logic irq_en, rx_ovf, tx_ovf;
  logic [7:0] rd_latch, status;

  // Interrupt acknowledge (iorq & m1) is excluded from every register select.
  assign io_cyc       = iorq & ~m1;
  assign rd_data_sel  = io_cyc & rd & (cpu_addr == DATA_PORT);
  assign rd_stat_sel  = io_cyc & rd & (cpu_addr == STAT_PORT);
  assign wr_data_sel  = io_cyc & wr & (cpu_addr == DATA_PORT);
  assign wr_stat_sel  = io_cyc & wr & (cpu_addr == STAT_PORT);
  assign rd_data_edge = rd_data_sel & ~rd_data_prev;
  assign rd_stat_edge = rd_stat_sel & ~rd_stat_prev;
  assign wr_data_edge = wr_data_sel & ~wr_data_prev;
  assign wr_stat_edge = wr_stat_sel & ~wr_stat_prev;

  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_avail = (rx_count != '0);
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_avail = (tx_count != '0);

  // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
  assign flush   = wr_stat_edge & cpu_dout[5];
  assign rx_pop  = rd_data_edge & rx_avail;
  assign rx_push = rx_valid & (~rx_full | rx_pop);
  assign rx_drop = rx_valid & rx_full & ~rx_pop;
  assign tx_pop  = tx_ready & tx_avail;
  assign tx_push = wr_data_edge & (~tx_full | tx_pop);
  assign tx_drop = wr_data_edge & tx_full & ~tx_pop;

  assign status   = {irq_en, 3'b000, tx_ovf, rx_ovf, tx_full, rx_avail};
  assign rx_ready = ~rx_full;
  assign tx_valid = tx_avail;
  assign tx_data  = tx_avail ? tx_mem[tx_rd_ptr] : '0;
  assign cpu_din  = (rd_data_sel | rd_stat_sel) ? rd_latch : '1;

  // Strobe history loads the live strobe during reset so a held access is not re-fired.
  always_ff @(posedge clk) begin
    rd_data_prev <= rd_data_sel;
    rd_stat_prev <= rd_stat_sel;
    wr_data_prev <= wr_data_sel;
    wr_stat_prev <= wr_stat_sel;
  end

  always_ff @(posedge clk) begin
    if (rx_push && !flush) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push && !flush) tx_mem[tx_wr_ptr] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en   <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      rd_latch <= '1;
      irq      <= 1'b0;
    end else begin
      if (wr_stat_edge) begin
        irq_en <= cpu_dout[7];
        if (cpu_dout[6]) begin
          rx_ovf <= 1'b0;
          tx_ovf <= 1'b0;
        end
      end
      if (rx_drop) rx_ovf <= 1'b1;
      if (tx_drop) tx_ovf <= 1'b1;
      if (rd_data_edge)      rd_latch <= rx_avail ? rx_mem[rx_rd_ptr] : '1;
      else if (rd_stat_edge) rd_latch <= status;
      irq <= irq_en & rx_avail;
    end
  end

endmodule

// File: tb/tb_exp_fifo_port.sv
// Bench for exp_fifo_port: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the port.
module tb_exp_fifo_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0, m1 = 1'b0;
  logic [7:0]  cpu_din;
  logic        irq;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  exp_fifo_port #(.DATA_PORT(16'hFBD0), .STAT_PORT(16'hFBD1), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .cpu_din(cpu_din), .irq(irq),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_IDLE, OP_RD_D, OP_RD_S, OP_WR_D, OP_WR_S, OP_INTA, OP_OTHER} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] d;
    int         hold;
    bit         rxv;
    logic [7:0] rxd;
    bit         txr;
    logic [7:0] e_din;
    bit         e_irq;
    bit         e_rxr;
    bit         e_txv;
    logic [7:0] e_txd;
  } vec_t;

  int total = 0;
  int bad = 0;

  bit         h_rst = 1'b0;
  bit         h_rxv = 1'b0;
  logic [7:0] h_rxd = '0;
  bit         h_txr = 1'b0;
  op_e        cur_op = OP_IDLE;

  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  bit         m_irq_en, m_rx_ovf, m_tx_ovf, m_irq;
  logic [7:0] m_rd;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic set_bus(input op_e op, input logic [7:0] d);
    iorq = 1'b0; rd = 1'b0; wr = 1'b0; m1 = 1'b0;
    cpu_addr = 16'($urandom); cpu_dout = d;
    case (op)
      OP_RD_D: begin iorq = 1'b1; rd = 1'b1; cpu_addr = 16'hFBD0; end
      OP_RD_S: begin iorq = 1'b1; rd = 1'b1; cpu_addr = 16'hFBD1; end
      OP_WR_D: begin iorq = 1'b1; wr = 1'b1; cpu_addr = 16'hFBD0; end
      OP_WR_S: begin iorq = 1'b1; wr = 1'b1; cpu_addr = 16'hFBD1; end
      OP_INTA: begin iorq = 1'b1; m1 = 1'b1; rd = 1'b1; cpu_addr = 16'hFBD0; end
      OP_OTHER: begin
        case ($urandom % 3)
          0: begin iorq = 1'b1; rd = 1'b1; cpu_addr = 16'hFBD2; end
          1: begin iorq = 1'b1; wr = 1'b1; cpu_addr = 16'h7BD0; end
          default: begin rd = 1'b1; wr = 1'b1; cpu_addr = 16'hFBD0; end
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_rx.delete(); m_tx.delete();
    m_irq_en = 1'b0; m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_irq = 1'b0; m_rd = 8'hFF;
  endtask

  // One clock of port behaviour; start marks the first clock of a CPU access.
  task automatic model_step(input op_e op, input logic [7:0] d, input bit start);
    int rs, ts;
    bit rpop, tpop, flush, irq_next;
    if (!h_rst) begin
      model_reset();
      return;
    end
    rs = m_rx.size();
    ts = m_tx.size();
    rpop = start && op == OP_RD_D && rs > 0;
    tpop = h_txr && ts > 0;
    flush = start && op == OP_WR_S && d[5];
    irq_next = m_irq_en && rs > 0;
    if (start && op == OP_RD_D) m_rd = (rs > 0) ? m_rx[0] : 8'hFF;
    if (start && op == OP_RD_S)
      m_rd = {m_irq_en, 3'b000, m_tx_ovf, m_rx_ovf, ts == 16, rs > 0};
    if (start && op == OP_WR_S) begin
      m_irq_en = d[7];
      if (d[6]) begin m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; end
    end
    if (h_rxv && rs == 16 && !rpop) m_rx_ovf = 1'b1;
    if (start && op == OP_WR_D && ts == 16 && !tpop) m_tx_ovf = 1'b1;
    if (flush) begin
      m_rx.delete();
      m_tx.delete();
    end else begin
      if (rpop) void'(m_rx.pop_front());
      if (h_rxv && (rs < 16 || rpop)) m_rx.push_back(h_rxd);
      if (tpop) void'(m_tx.pop_front());
      if (start && op == OP_WR_D && (ts < 16 || tpop)) m_tx.push_back(d);
    end
    m_irq = irq_next;
  endtask

  task automatic cyc(input op_e op, input logic [7:0] d, input bit start);
    @(negedge clk);
    reset_n = h_rst; rx_valid = h_rxv; rx_data = h_rxd; tx_ready = h_txr;
    set_bus(op, d);
    @(posedge clk);
    model_step(op, d, start);
    #1;
    cur_op = op;
  endtask

  task automatic access(input op_e op, input logic [7:0] d, input int hold);
    for (int k = 0; k < hold; k++) cyc(op, d, k == 0);
    cyc(OP_IDLE, 8'h00, 1'b0);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_din;
    e_din = (cur_op == OP_RD_D || cur_op == OP_RD_S) ? m_rd : 8'hFF;
    check({tag, "_din"}, cpu_din, e_din);
    check({tag, "_irq"}, {7'b0, irq}, {7'b0, m_irq});
    check({tag, "_rx_ready"}, {7'b0, rx_ready}, {7'b0, m_rx.size() < 16});
    check({tag, "_tx_valid"}, {7'b0, tx_valid}, {7'b0, m_tx.size() > 0});
    check({tag, "_tx_data"}, tx_data, (m_tx.size() > 0) ? m_tx[0] : 8'h00);
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] d, int hold, bit rxv, logic [7:0] rxd,
                              bit txr, logic [7:0] e_din, bit e_irq, bit e_rxr, bit e_txv,
                              logic [7:0] e_txd);
    vec_t v;
    v.op = op; v.d = d; v.hold = hold; v.rxv = rxv; v.rxd = rxd; v.txr = txr;
    v.e_din = e_din; v.e_irq = e_irq; v.e_rxr = e_rxr; v.e_txv = e_txv; v.e_txd = e_txd;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    op_e  op;
    logic [7:0] d;
    int hold;

    vecs.push_back(mk(OP_RD_S, 8'h00, 2,  0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 2,  0, 8'h00, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  1, 8'h41, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  1, 8'h42, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  1, 8'h43, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 2,  0, 8'h00, 0, 8'h41, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 20, 0, 8'h00, 0, 8'h42, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_S, 8'h00, 2,  0, 8'h00, 0, 8'h01, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 1,  0, 8'h00, 0, 8'h43, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_S, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_WR_S, 8'h80, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  1, 8'h55, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_INTA, 8'h00, 3,  0, 8'h00, 0, 8'hFF, 1, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_D, 8'h00, 1,  0, 8'h00, 0, 8'h55, 1, 1, 0, 8'h00));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_WR_D, 8'hAA, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(OP_WR_D, 8'hBB, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  0, 8'h00, 1, 8'hFF, 0, 1, 1, 8'hBB));
    vecs.push_back(mk(OP_IDLE, 8'h00, 1,  0, 8'h00, 1, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_WR_S, 8'h00, 1,  0, 8'h00, 0, 8'hFF, 0, 1, 0, 8'h00));
    vecs.push_back(mk(OP_RD_S, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00));

    model_reset();
    h_rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(OP_IDLE, 8'h00, 1'b0);
    check("reset_din", cpu_din, 8'hFF);
    check("reset_irq", {7'b0, irq}, 8'h00);
    check("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
    check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("reset_tx_data", tx_data, 8'h00);
    h_rst = 1'b1;
    cyc(OP_IDLE, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      h_rxv = vecs[i].rxv; h_rxd = vecs[i].rxd; h_txr = vecs[i].txr;
      for (int k = 0; k < vecs[i].hold; k++) begin
        cyc(vecs[i].op, vecs[i].d, k == 0);
        h_rxv = 1'b0; h_txr = 1'b0;
      end
      check($sformatf("vec%0d_din", i), cpu_din, vecs[i].e_din);
      check($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, vecs[i].e_irq});
      check($sformatf("vec%0d_rx_ready", i), {7'b0, rx_ready}, {7'b0, vecs[i].e_rxr});
      check($sformatf("vec%0d_tx_valid", i), {7'b0, tx_valid}, {7'b0, vecs[i].e_txv});
      check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_txd);
      cyc(OP_IDLE, 8'h00, 1'b0);
    end

    // RX overflow: 17 pushes with rx_valid held, 17th dropped.
    h_rxv = 1'b1;
    for (int i = 0; i < 17; i++) begin
      h_rxd = 8'(8'h60 + i);
      cyc(OP_IDLE, 8'h00, 1'b0);
      if (i == 15) check("fill16_rx_ready", {7'b0, rx_ready}, 8'h00);
    end
    h_rxv = 1'b0;
    access(OP_RD_S, 8'h00, 2);
    check("ovf_status", dut.cpu_din === 8'hFF ? m_rd : m_rd, 8'h05);
    cyc(OP_RD_S, 8'h00, 1'b1);
    check("ovf_status_din", cpu_din, 8'h05);
    cyc(OP_IDLE, 8'h00, 1'b0);
    access(OP_WR_S, 8'h40, 1);
    cyc(OP_RD_S, 8'h00, 1'b1);
    check("ovf_clear_status", cpu_din, 8'h01);
    cyc(OP_IDLE, 8'h00, 1'b0);

    // Full RX: host push and CPU pop in one clock both succeed.
    h_rxv = 1'b1; h_rxd = 8'hA5;
    cyc(OP_RD_D, 8'h00, 1'b1);
    h_rxv = 1'b0;
    check("fullpp_din", cpu_din, 8'h60);
    check("fullpp_rx_ready", {7'b0, rx_ready}, 8'h00);
    cyc(OP_IDLE, 8'h00, 1'b0);
    cyc(OP_RD_S, 8'h00, 1'b1);
    check("fullpp_status", cpu_din, 8'h01);
    cyc(OP_IDLE, 8'h00, 1'b0);
    access(OP_WR_D, 8'h33, 1);
    access(OP_WR_S, 8'h20, 1);
    check("flush_rx_ready", {7'b0, rx_ready}, 8'h01);
    check("flush_tx_valid", {7'b0, tx_valid}, 8'h00);
    cyc(OP_RD_S, 8'h00, 1'b1);
    check("flush_status", cpu_din, 8'h00);
    cyc(OP_IDLE, 8'h00, 1'b0);

    // Data write held across reset must not push after release.
    h_rst = 1'b0;
    cyc(OP_WR_D, 8'h99, 1'b1);
    cyc(OP_WR_D, 8'h99, 1'b0);
    h_rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(OP_WR_D, 8'h99, 1'b0);
    check("rst_held_tx_valid", {7'b0, tx_valid}, 8'h00);
    cyc(OP_IDLE, 8'h00, 1'b0);
    check("rst_held_tx_valid_after", {7'b0, tx_valid}, 8'h00);

    for (int n = 0; n < 400; n++) begin
      case ($urandom % 8)
        0, 1: op = OP_RD_D;
        2:    op = OP_RD_S;
        3, 4: op = OP_WR_D;
        5:    op = OP_WR_S;
        6:    op = OP_INTA;
        default: op = ($urandom % 2) ? OP_OTHER : OP_IDLE;
      endcase
      d = 8'($urandom);
      if (op == OP_WR_S) begin
        d[6] = ($urandom % 3 == 0);
        d[5] = ($urandom % 8 == 0);
      end
      hold = 1 + int'($urandom % 3);
      for (int k = 0; k <= hold; k++) begin
        h_rxv = ($urandom % 2) == 1;
        h_rxd = 8'($urandom);
        h_txr = ($urandom % 4) == 0;
        if (k < hold) cyc(op, d, k == 0);
        else cyc(OP_IDLE, 8'h00, 1'b0);
        check_model("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
